serial_add_ctrl: RTL

Bit-serial add/subtract sequencer that time-shares one `full_adder` cell across a WIDTH-bit operand pair. It processes one bit per clock, LSB first, and holds the carry between cycles in a flip-flop. It sits between an issuing controller (start/ready handshake) and the consumers of the sum, and trades latency for area against a parallel ripple adder. Results, carry-out and signed overflow are registered and held until the next operation is accepted.

---
 rtl/alu_pkg.sv | 6 +
 rtl/full_adder.sv | 15 +
 rtl/serial_add_ctrl.sv | 73 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings and sequencer state type
package alu_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit adder cell with propagate/generate outputs
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co,
  output logic p,
  output logic g
);
  assign p  = a ^ b;
  assign g  = a & b;
  assign s  = p ^ ci;
  assign co = g | (p & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer sharing one full_adder, LSB first
module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             carry, s_bit, c_bit, last;
  full_adder fa (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .s(s_bit), .co(c_bit), .p(), .g());
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && ready) begin
        a_sh  <= inA;
        b_sh  <= inB ^ {WIDTH{op}};
        carry <= (op == OP_SUB) ? 1'b1 : cin;
        cnt   <= '0;
        state <= RUN;
        busy  <= 1'b1;
        ready <= 1'b0;
      end else if (state == RUN) begin
        res   <= {s_bit, res[WIDTH-1:1]};
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= c_bit;
        cnt   <= cnt + CW'(1);
        if (last) begin
          // carry flop still holds the carry into the MSB here
          sum   <= {s_bit, res[WIDTH-1:1]};
          cout  <= c_bit;
          ovf   <= c_bit ^ carry;
          state <= DONE;
          busy  <= 1'b0;
          ready <= 1'b1;
          done  <= 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule
